reg_file_scoreboard: RTL and testbench
======================================

Name: reg_file_scoreboard

Overview:
- 16-entry x 16-bit register file with two combinational read ports, one synchronous write port, and a per-register pending-write scoreboard.
- Sits between instruction decode, which issues source and destination register IDs, and writeback, which returns results.
- Stores architectural state and raises Hazard so decode stalls any instruction whose sources, or whose destination counter, are not ready.
- Write enables come from a one-hot 4-to-16 decode of DstReg.

Parameters:
- DATA_W, 16: register width in bits.
- NUM_REGS, 16: register count. Fixed at 16, so register IDs are 4 bits.
- CNT_W, 2: width of each pending-write counter. Maximum value is 3.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- SrcReg1  in  4  read port 1 register ID.
- SrcReg2  in  4  read port 2 register ID.
- Src1Used  in  1  instruction in decode reads SrcReg1.
- Src2Used  in  1  instruction in decode reads SrcReg2.
- SrcData1  out  16  read data, port 1.
- SrcData2  out  16  read data, port 2.
- IssueValid  in  1  decode attempts to issue an instruction this cycle.
- IssueWr  in  1  the issuing instruction writes a register.
- IssueDst  in  4  destination register of the issuing instruction.
- Hazard  out  1  issue blocked this cycle (combinational).
- WriteReg  in  1  writeback valid.
- DstReg  in  4  writeback register ID.
- DstData  in  16  writeback data.
- SbError  out  1  sticky flag: writeback arrived for a register with no pending write.

Behaviour:
- Reset (asynchronous, rst=1):
  - All registers = 0x0000.
  - All pending counters = 0.
  - SbError = 0.
  - Consequently SrcData1/2 = 0x0000 and Hazard = 0 while rst is held.
- R0:
  - Always reads 0x0000.
  - Writes to R0 are ignored and do not touch the scoreboard.
  - Issues with IssueDst=0 never increment.
- Write: on the rising clk edge, regs[DstReg] <= DstData when WriteReg=1 and DstReg!=0.
- Read:
  - Combinational: SrcDataN = regs[SrcRegN], zero latency.
  - Bypass (feature on): if WriteReg=1, DstReg==SrcRegN and DstReg!=0, then SrcDataN = DstData in the same cycle.
- busy[r]:
  - cnt[r]!=0.
  - Feature on: a register is not busy when cnt[r]==1 and a writeback to r occurs this cycle.
- Hazard = (Src1Used & busy[SrcReg1]) | (Src2Used & busy[SrcReg2]) | (IssueValid & IssueWr & IssueDst!=0 & cnt[IssueDst]==3).
- Issue is accepted only when IssueValid=1 and Hazard=0.
- Counter update per register r, each clk edge:
  - inc = accepted issue with IssueWr=1 and IssueDst==r (r!=0).
  - dec = WriteReg=1 and DstReg==r (r!=0).
  - inc & dec: count unchanged.
  - inc only: +1. Saturation cannot occur because Hazard blocks an issue at 3.
  - dec only with cnt>0: -1.
  - dec only with cnt==0: count stays 0 and SbError is set. SbError clears only on rst.
- Reset mid-operation: all pending counts and data are discarded immediately; no writeback is honoured while rst=1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Same-cycle write-through to both read ports.
  - A busy register with cnt==1 being written this cycle is treated as ready (no stall).
- Undefined:
  - Reads return pre-write contents; new data is visible the cycle after the write.
  - busy[r] = cnt[r]!=0 with no writeback exception, so the instruction stalls one extra cycle.
- Scoreboard counting is identical in both builds.

Decomposition:
- Shared package:
  - DATA_W, NUM_REGS, REG_ID_W=4, CNT_W, PEND_MAX=3, REG_ZERO=4'd0.
  - Typedef reg_id_t (4 bits) and data_t (16 bits).
- Sub-module pend_counter: a CNT_W up/down counter with inc/dec inputs, a cnt output and an underflow pulse, instantiated 15 times (R1-R15).
- The underflow pulses are ORed into SbError.

Test Plan:
- Reset then read: rst pulse, SrcReg1=5, SrcReg2=0 -> SrcData1=0x0000, SrcData2=0x0000, Hazard=0, SbError=0.
- Write then read: write R3=0xBEEF, next cycle SrcReg1=3 -> SrcData1=0xBEEF.
- Same-cycle write and read of R3=0x1234:
  - Bypass on -> SrcData1=0x1234 that cycle.
  - Bypass off -> old value that cycle, 0x1234 the next cycle.
- Hazard and release:
  - Issue IssueDst=7.
  - Next cycle Src1Used=1, SrcReg1=7 -> Hazard=1.
  - Writeback R7=0x00AA.
  - Bypass on -> Hazard=0 in the writeback cycle with SrcData1=0x00AA.
  - Bypass off -> Hazard=0 one cycle later.
- Saturation: three accepted issues to R9, fourth issue to R9 -> Hazard=1 and cnt stays 3. Three writebacks return cnt to 0. A fourth writeback sets SbError=1, which stays set until rst.
- R0 and async reset:
  - Write R0=0xFFFF -> reads 0x0000.
  - Issue to R0 -> no hazard.
  - Assert rst mid-cycle with cnt[4]=2 -> immediate clear, Hazard on R4=0.

Source files
------------

// File: rtl/reg_file_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_scoreboard_pkg
// Purpose  : Shared sizes and types for the register file / scoreboard
//            block and its pending-write counter sub-module.
// Revision : 1.0 - initial release
// ============================================================================
package reg_file_scoreboard_pkg;

  localparam int DATA_W   = 16;  // register width
  localparam int NUM_REGS = 16;  // fixed register count
  localparam int REG_ID_W = 4;   // log2(NUM_REGS)
  localparam int CNT_W    = 2;   // pending-write counter width
  localparam int PEND_MAX = 3;   // largest pending count a register can hold

  typedef logic [REG_ID_W-1:0] reg_id_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [CNT_W-1:0]    cnt_t;

  localparam reg_id_t REG_ZERO = 4'd0;

endpackage : reg_file_scoreboard_pkg
`default_nettype wire

// File: rtl/reg_file_scoreboard_pend_counter.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_scoreboard_pend_counter
// Purpose  : Pending-write counter for one register. Counts issued writes
//            not yet returned by writeback. A simultaneous inc and dec
//            cancel. A dec with nothing pending holds at zero and raises a
//            one-cycle underflow indication.
// Ports    : clk          - rising-edge clock
//            rst          - asynchronous active-high reset
//            i_inc        - accepted issue targeting this register
//            i_dec        - writeback to this register
//            o_cnt        - current pending count
//            o_underflow  - dec-only with count already zero (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_scoreboard_pend_counter
  import reg_file_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_underflow
);

  cnt_t r_cnt;

  // Increment never overflows: the owning block refuses issues at PEND_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      case ({i_inc, i_dec})
        2'b10:   r_cnt <= r_cnt + cnt_t'(1);
        2'b01:   if (r_cnt != '0) r_cnt <= r_cnt - cnt_t'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_cnt       = r_cnt;
  assign o_underflow = i_dec & ~i_inc & (r_cnt == '0);

endmodule : reg_file_scoreboard_pend_counter
`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_scoreboard
// Purpose  : 16 x 16-bit register file with two combinational read ports,
//            one synchronous write port and a per-register pending-write
//            scoreboard that raises Hazard so decode can stall.
//            R0 is hard-wired to zero and never tracked.
// Config   : REGFILE_BYPASS_EN - when defined, writeback data is forwarded
//            to both read ports in the same cycle and a register whose last
//            pending write is returning this cycle is treated as ready.
// Ports    : clk, rst               - clock, asynchronous active-high reset
//            SrcReg1/2, Src1/2Used  - decode source IDs and their use flags
//            SrcData1/2             - combinational read data
//            IssueValid/Wr/Dst      - decode issue attempt and destination
//            Hazard                 - issue blocked this cycle
//            WriteReg/DstReg/Data   - writeback port
//            SbError                - sticky writeback-without-pending flag
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_ID_W-1:0] SrcReg1,
  input  logic [REG_ID_W-1:0] SrcReg2,
  input  logic                Src1Used,
  input  logic                Src2Used,
  output logic [DATA_W-1:0]   SrcData1,
  output logic [DATA_W-1:0]   SrcData2,
  input  logic                IssueValid,
  input  logic                IssueWr,
  input  logic [REG_ID_W-1:0] IssueDst,
  output logic                Hazard,
  input  logic                WriteReg,
  input  logic [REG_ID_W-1:0] DstReg,
  input  logic [DATA_W-1:0]   DstData,
  output logic                SbError
);

  localparam logic [NUM_REGS-1:0] c_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  data_t                     r_regs [NUM_REGS];
  logic                      r_sb_error;
  logic [NUM_REGS-1:0]       w_we;       // one-hot writeback enable, bit 0 masked
  logic [NUM_REGS-1:0]       w_inc;      // one-hot accepted issue, bit 0 masked
  logic [NUM_REGS-1:0]       w_busy;
  logic [NUM_REGS-1:0]       w_uflow;
  logic [NUM_REGS-1:0][CNT_W-1:0] w_cnt;
  logic                      w_accept;
  logic                      w_dst_full;

  // --------------------------------------------------------------------------
  // One-hot decodes. Masking bit 0 makes R0 writes and R0 issues vanish
  // from both the data array and the scoreboard.
  // --------------------------------------------------------------------------
  always_comb begin
    w_we     = WriteReg ? (c_ONE << DstReg) : '0;
    w_we[0]  = 1'b0;
    w_inc    = (w_accept & IssueWr) ? (c_ONE << IssueDst) : '0;
    w_inc[0] = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Register array. Entry 0 is only ever reset, so it reads as zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_we[i]) r_regs[i] <= DstData;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports. Forwarding is suppressed under reset so the outputs are
  // zero for as long as rst is held.
  // --------------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
  assign SrcData1 = (!rst && w_we[SrcReg1]) ? DstData : r_regs[SrcReg1];
  assign SrcData2 = (!rst && w_we[SrcReg2]) ? DstData : r_regs[SrcReg2];
`else
  assign SrcData1 = r_regs[SrcReg1];
  assign SrcData2 = r_regs[SrcReg2];
`endif

  // --------------------------------------------------------------------------
  // Pending-write counters for R1..R15.
  // --------------------------------------------------------------------------
  assign w_cnt[0]   = '0;
  assign w_uflow[0] = 1'b0;

  generate
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_pend
      reg_file_scoreboard_pend_counter u_cnt (
        .clk         (clk),
        .rst         (rst),
        .i_inc       (w_inc[r]),
        .i_dec       (w_we[r]),
        .o_cnt       (w_cnt[r]),
        .o_underflow (w_uflow[r])
      );
    end : g_pend
  endgenerate

  // --------------------------------------------------------------------------
  // Busy / hazard. With forwarding, the final outstanding write arriving
  // this cycle releases the register immediately.
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
`ifdef REGFILE_BYPASS_EN
      w_busy[i] = (w_cnt[i] != '0) && !((w_cnt[i] == cnt_t'(1)) && w_we[i]);
`else
      w_busy[i] = (w_cnt[i] != '0);
`endif
    end
  end

  assign w_dst_full = IssueValid & IssueWr & (IssueDst != REG_ZERO) &
                      (w_cnt[IssueDst] == cnt_t'(PEND_MAX));

  assign Hazard   = (Src1Used & w_busy[SrcReg1]) |
                    (Src2Used & w_busy[SrcReg2]) |
                    w_dst_full;
  assign w_accept = IssueValid & ~Hazard;

  // --------------------------------------------------------------------------
  // Sticky scoreboard error, cleared only by reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_error <= 1'b0;
    end else if (|w_uflow) begin
      r_sb_error <= 1'b1;
    end
  end

  assign SbError = r_sb_error;

endmodule : reg_file_scoreboard
`default_nettype wire

// File: tb/tb_reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_scoreboard
// Purpose  : Self-checking bench for reg_file_scoreboard. Directed steps
//            followed by randomized traffic, compared against a behavioural
//            model of register contents and outstanding-write counts.
// Config   : REGFILE_BYPASS_EN - must match the build of the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  SrcReg1, SrcReg2, IssueDst, DstReg;
  logic        Src1Used, Src2Used, IssueValid, IssueWr, WriteReg;
  logic [15:0] DstData, SrcData1, SrcData2;
  logic        Hazard, SbError;

  always #5 clk = ~clk;

  reg_file_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .SrcReg1    (SrcReg1),
    .SrcReg2    (SrcReg2),
    .Src1Used   (Src1Used),
    .Src2Used   (Src2Used),
    .SrcData1   (SrcData1),
    .SrcData2   (SrcData2),
    .IssueValid (IssueValid),
    .IssueWr    (IssueWr),
    .IssueDst   (IssueDst),
    .Hazard     (Hazard),
    .WriteReg   (WriteReg),
    .DstReg     (DstReg),
    .DstData    (DstData),
    .SbError    (SbError)
  );

  // Behavioural model: architectural values and outstanding write counts.
  logic [15:0] m_regs [16];
  int          m_pend [16];
  logic        m_sberr;
  int          checks = 0;
  int          errors = 0;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 16'h0000;
      m_pend[i] = 0;
    end
    m_sberr = 1'b0;
  endfunction

  function automatic logic wb_hits(int r);
    return WriteReg && (r != 0) && (int'(DstReg) == r);
  endfunction

  function automatic logic m_busy(int r);
    if (r == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (m_pend[r] == 1 && wb_hits(r)) return 1'b0;
`endif
    return m_pend[r] > 0;
  endfunction

  function automatic logic m_hazard();
    return (Src1Used && m_busy(int'(SrcReg1))) ||
           (Src2Used && m_busy(int'(SrcReg2))) ||
           (IssueValid && IssueWr && IssueDst != 4'd0 && m_pend[IssueDst] >= 3);
  endfunction

  function automatic logic [15:0] m_read(int r);
    if (rst || r == 0) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if (wb_hits(r)) return DstData;
`endif
    return m_regs[r];
  endfunction

  // Applies one clock edge of the specified behaviour to the model.
  function automatic void model_edge();
    logic accept;
    if (rst) begin
      model_reset();
      return;
    end
    accept = IssueValid && !m_hazard();
    for (int r = 1; r < 16; r++) begin
      logic inc, dec;
      inc = accept && IssueWr && int'(IssueDst) == r;
      dec = wb_hits(r);
      if (inc && !dec) m_pend[r]++;
      else if (dec && !inc) begin
        if (m_pend[r] > 0) m_pend[r]--;
        else m_sberr = 1'b1;
      end
    end
    if (WriteReg && DstReg != 4'd0) m_regs[DstReg] = DstData;
  endfunction

  task automatic check(input string tag);
    logic [15:0] e1, e2;
    logic        eh, es;
    e1 = m_read(int'(SrcReg1));
    e2 = m_read(int'(SrcReg2));
    eh = rst ? 1'b0 : m_hazard();
    es = m_sberr;
    checks++;
    assert (SrcData1 === e1) else begin
      errors++;
      $error("FAIL %s SrcData1 observed=%h expected=%h", tag, SrcData1, e1);
    end
    checks++;
    assert (SrcData2 === e2) else begin
      errors++;
      $error("FAIL %s SrcData2 observed=%h expected=%h", tag, SrcData2, e2);
    end
    checks++;
    assert (Hazard === eh) else begin
      errors++;
      $error("FAIL %s Hazard observed=%b expected=%b", tag, Hazard, eh);
    end
    checks++;
    assert (SbError === es) else begin
      errors++;
      $error("FAIL %s SbError observed=%b expected=%b", tag, SbError, es);
    end
  endtask

  task automatic idle();
    SrcReg1 = 4'd0; SrcReg2 = 4'd0; Src1Used = 1'b0; Src2Used = 1'b0;
    IssueValid = 1'b0; IssueWr = 1'b0; IssueDst = 4'd0;
    WriteReg = 1'b0; DstReg = 4'd0; DstData = 16'h0000;
  endtask

  // Check at the falling edge, then advance the model with the rising edge.
  task automatic tick(input string tag);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic issue(input logic [3:0] dst);
    idle(); IssueValid = 1'b1; IssueWr = 1'b1; IssueDst = dst;
  endtask

  task automatic wb(input logic [3:0] dst, input logic [15:0] d);
    idle(); WriteReg = 1'b1; DstReg = dst; DstData = d;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_reset();
    SrcReg1 = 4'd5; SrcReg2 = 4'd0;
    tick("reset_held");
    rst = 1'b0;
    SrcReg1 = 4'd5;
    tick("after_reset");

    // Write then read.
    wb(4'd3, 16'hBEEF);            tick("wr_r3");
    idle(); SrcReg1 = 4'd3;        tick("rd_r3");

    // Same-cycle write and read.
    wb(4'd3, 16'h1234); SrcReg1 = 4'd3; SrcReg2 = 4'd3; tick("wr_rd_same");
    idle(); SrcReg1 = 4'd3;        tick("rd_r3_next");

    // Hazard and release.
    issue(4'd7);                   tick("issue7");
    idle(); Src1Used = 1'b1; SrcReg1 = 4'd7; tick("haz7");
    wb(4'd7, 16'h00AA); Src1Used = 1'b1; SrcReg1 = 4'd7; tick("wb7");
    idle(); Src1Used = 1'b1; SrcReg1 = 4'd7; tick("post_wb7");

    // Saturation at three outstanding writes; fourth issue blocked.
    repeat (4) begin issue(4'd9); tick("issue9"); end
    repeat (3) begin
      wb(4'd9, 16'h0909); Src2Used = 1'b1; SrcReg2 = 4'd9; tick("wb9");
    end
    idle(); Src2Used = 1'b1; SrcReg2 = 4'd9; tick("r9_free");
    wb(4'd9, 16'h9999);            tick("wb9_extra");
    idle(); SrcReg1 = 4'd9;        tick("sberr_set");
    idle();                        tick("sberr_sticky");

    // R0 behaviour.
    wb(4'd0, 16'hFFFF);            tick("wr_r0");
    idle(); SrcReg1 = 4'd0; SrcReg2 = 4'd0; tick("rd_r0");
    issue(4'd0); Src1Used = 1'b1; SrcReg1 = 4'd0; tick("issue_r0");
    idle(); Src1Used = 1'b1; SrcReg1 = 4'd0; tick("r0_ready");

    // Asynchronous reset with two writes outstanding on R4.
    issue(4'd4); tick("issue4a");
    issue(4'd4); tick("issue4b");
    idle(); Src1Used = 1'b1; SrcReg1 = 4'd4; SrcReg2 = 4'd3;
    @(negedge clk);
    check("r4_busy");
    #2 rst = 1'b1;
    model_reset();
    #1 check("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    tick("after_async_rst");

    // Randomized traffic on a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      SrcReg1    = 4'($urandom_range(0, 6));
      SrcReg2    = 4'($urandom_range(0, 6));
      Src1Used   = 1'($urandom_range(0, 1));
      Src2Used   = 1'($urandom_range(0, 1));
      IssueValid = 1'($urandom_range(0, 1));
      IssueWr    = 1'($urandom_range(0, 3) != 0);
      IssueDst   = 4'($urandom_range(0, 6));
      WriteReg   = ($urandom_range(0, 2) == 0);
      DstReg     = 4'($urandom_range(0, 6));
      DstData    = 16'($urandom);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_reg_file_scoreboard
`default_nettype wire
